pio_master: RTL and testbench
=============================

Name: pio_master

Overview:
- PIO initiator for the register bus: accepts one host request at a time and drives reg_bs/reg_rd/reg_wr/reg_addr/reg_din toward NBLK register slaves.
- Collects the targeted slave's pio_ack (write done) or pio_rvalid/pio_rdata (read done) and returns a single response to the host.
- Provides per-transaction timeout, out-of-range block error, and drain of stale slave completions.
- Sits between the host/CSR command path and the per-block register files.

Parameters:
- PIO_NBITS, 32, address and data width.
- NBLK, 4, number of slaves; one reg_bs bit and one response slice per slave.
- BLK_SEL_LSB, 12, LSB of the block-index field in req_addr.
- BLK_SEL_NBITS, 2, width of the block-index field.
- TIMEOUT_CYC, 1023, clk cycles in WAIT before error; counter 16 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- clk_div  in  1  slave pacing strobe, passed through; slave completions change only on cycles where clk_div=1.
- req_valid  in  1  host request valid.
- req_ready  out  1  request accepted this cycle when req_valid&req_ready.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  PIO_NBITS  register address.
- req_wdata  in  PIO_NBITS  write data.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  host accepts the response.
- resp_rdata  out  PIO_NBITS  read data; 0 for writes; all-ones on error.
- resp_err  out  1  timeout or out-of-range.
- reg_bs  out  NBLK  one-hot block select.
- reg_rd  out  1  read strobe.
- reg_wr  out  1  write strobe.
- reg_addr  out  PIO_NBITS  bus address.
- reg_din  out  PIO_NBITS  bus write data.
- pio_ack  in  NBLK  per-slave write completion, level.
- pio_rvalid  in  NBLK  per-slave read completion, level.
- pio_rdata  in  NBLK*PIO_NBITS  per-slave read data; slice i = [i*PIO_NBITS +: PIO_NBITS].

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- blk = req_addr[BLK_SEL_LSB +: BLK_SEL_NBITS], latched on accept.
- States: IDLE, STROBE, WAIT, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On accept with blk<NBLK: latch addr, wdata, wr and blk; go to STROBE.
  - On accept with blk>=NBLK: go to RESP with resp_err=1 and rdata all-ones. No bus activity.
- STROBE (exactly 1 cycle):
  - reg_bs[blk]=1; reg_rd=~wr, reg_wr=wr; reg_addr/reg_din driven.
  - Go to WAIT. Counter cleared.
- WAIT:
  - reg_bs[blk], reg_addr and reg_din held stable; strobes 0. Slave read data is decoded combinationally from reg_addr, so the address must not change.
  - Write completes on pio_ack[blk]=1. Read completes on pio_rvalid[blk]=1, capturing the pio_rdata slice blk in that same cycle.
  - On completion: go to DRAIN with resp_err=0.
  - If no completion when counter==TIMEOUT_CYC: go to DRAIN with resp_err=1, rdata all-ones.
  - Completion in the same cycle as expiry: completion wins.
  - Ack/rvalid of non-selected slaves is ignored.
- DRAIN:
  - reg_bs=0, reg_addr/reg_din hold their last value.
  - Stay until pio_ack[blk]=0 and pio_rvalid[blk]=0 (levels persist up to one clk_div period), then go to RESP.
  - Leaving DRAIN is not gated by timeout; DRAIN is exited when both are already 0 on entry.
- RESP:
  - resp_valid=1 with rdata and err stable.
  - On resp_ready go to IDLE; the next request can be accepted the following cycle.
- Latency: accept to STROBE is 1 cycle; minimum accept to resp_valid is 4 cycles.
- One outstanding transaction only; req_ready=0 outside IDLE.
- rst mid-transaction: all outputs 0 on the next cycle and state IDLE; in-flight response discarded.

Test Plan:
- Write 0x0000_1004 data 0x0000_0003; blk1 pio_ack[1]=1 4 cycles after strobe, held 2 cycles -> reg_wr 1-cycle pulse with reg_bs=4'b0010; resp_valid after ack drops; resp_err=0, resp_rdata=0.
- Read 0x0000_2008; blk2 pio_rvalid[2]=1 with slice2=0x0000_ABCD, while slice0=0xFFFF_FFFF -> resp_rdata=0x0000_ABCD; reg_addr stable from STROBE through WAIT.
- Read to blk3, no completion -> after TIMEOUT_CYC+1 WAIT cycles resp_err=1, resp_rdata=0xFFFF_FFFF.
- Address 0x0000_4000 with BLK_SEL_NBITS=3, NBLK=4 (blk=4) -> reg_bs never asserted; resp_err=1 within 2 cycles.
- pio_ack[0] held high from a prior write when a new write to blk0 is issued -> master stays in DRAIN until it falls.
- Stray pio_ack[2] during a blk1 wait is ignored.
- resp_ready held 0 for 5 cycles -> resp_valid/data stable and req_ready=0 throughout.
- rst pulsed during WAIT -> reg_bs=0, resp_valid=0 next cycle; a new request is accepted normally.

Source files
------------

// File: rtl/pio_master_if.sv
// Host request/response channel and register-bus channel of the PIO initiator.
// master: the pio_master side. slave: the host plus register-slave environment.
interface pio_master_if #(
    parameter int PIO_NBITS = 32,
    parameter int NBLK      = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wr;
    logic [PIO_NBITS-1:0]      req_addr;
    logic [PIO_NBITS-1:0]      req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [PIO_NBITS-1:0]      resp_rdata;
    logic                      resp_err;
    logic [NBLK-1:0]           reg_bs;
    logic                      reg_rd;
    logic                      reg_wr;
    logic [PIO_NBITS-1:0]      reg_addr;
    logic [PIO_NBITS-1:0]      reg_din;
    logic [NBLK-1:0]           pio_ack;
    logic [NBLK-1:0]           pio_rvalid;
    logic [NBLK*PIO_NBITS-1:0] pio_rdata;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
               pio_ack, pio_rvalid, pio_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               reg_bs, reg_rd, reg_wr, reg_addr, reg_din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, resp_ready,
               pio_ack, pio_rvalid, pio_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               reg_bs, reg_rd, reg_wr, reg_addr, reg_din
    );
endinterface

// File: rtl/pio_master.sv
// PIO initiator: one host request at a time, one strobe toward the selected
// register block, wait for its completion level (or time out), drain the
// stale level, then hold a single response until the host takes it.
module pio_master #(
    parameter int PIO_NBITS     = 32,
    parameter int NBLK          = 4,
    parameter int BLK_SEL_LSB   = 12,
    parameter int BLK_SEL_NBITS = 2,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_div,
    pio_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT, DRAIN, RESP} state_t;

    localparam logic [BLK_SEL_NBITS:0] NBLK_LIM    = (BLK_SEL_NBITS+1)'(NBLK);
    localparam logic [15:0]            TIMEOUT_VAL = 16'(TIMEOUT_CYC);

    state_t                   state_q, state_d;
    logic [PIO_NBITS-1:0]     addr_q, addr_d;
    logic [PIO_NBITS-1:0]     wdata_q, wdata_d;
    logic                     wr_q, wr_d;
    logic [NBLK-1:0]          bs_q, bs_d;
    logic [PIO_NBITS-1:0]     rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [BLK_SEL_NBITS-1:0] req_blk;
    logic [NBLK-1:0]          req_onehot;
    logic                     ack_sel;
    logic                     rvalid_sel;
    logic [PIO_NBITS-1:0]     rdata_sel;

    // Slave completions are already paced by clk_div on the slave side; the
    // master only watches their levels, so the strobe is not needed here.
    logic unused_clk_div;
    assign unused_clk_div = clk_div;

    // Decode the requested block and pick out the latched block's completion lines and read data.
    always_comb begin
        req_blk    = bus.req_addr[BLK_SEL_LSB +: BLK_SEL_NBITS];
        req_onehot = {{(NBLK-1){1'b0}}, 1'b1} << req_blk;
        ack_sel    = |(bus.pio_ack & bs_q);
        rvalid_sel = |(bus.pio_rvalid & bs_q);
        rdata_sel  = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (bs_q[i]) begin
                rdata_sel = bus.pio_rdata[i*PIO_NBITS +: PIO_NBITS];
            end
        end
    end

    // State and datapath registers; reset returns to IDLE and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            bs_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            bs_q    <= bs_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept, strobe, wait with timeout (completion wins a tie), drain, respond.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        bs_d    = bs_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if ({1'b0, req_blk} < NBLK_LIM) begin
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        wr_d    = bus.req_wr;
                        bs_d    = req_onehot;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = STROBE;
                    end else begin
                        rdata_d = '1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            STROBE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wr_q ? ack_sel : rvalid_sel) begin
                    rdata_d = wr_q ? '0 : rdata_sel;
                    err_d   = 1'b0;
                    state_d = DRAIN;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (!ack_sel && !rvalid_sel) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state; address and data stay parked on the bus between transactions.
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !rst;
        bus.reg_bs     = (state_q == STROBE || state_q == WAIT) ? bs_q : '0;
        bus.reg_rd     = (state_q == STROBE) && !wr_q;
        bus.reg_wr     = (state_q == STROBE) && wr_q;
        bus.reg_addr   = addr_q;
        bus.reg_din    = wdata_q;
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.resp_err   = (state_q == RESP) && err_q;
    end

endmodule

// File: tb/tb_pio_master.sv
// Self-checking bench for pio_master: directed cases plus randomized
// transactions, each judged against a cycle-level timing model of the
// request/strobe/wait/drain/response sequence.
module tb_pio_master;

    localparam int NBITS   = 32;
    localparam int NBLK    = 4;
    localparam int TIMEOUT = 1023;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic clk_div = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    pio_master_if #(.PIO_NBITS(NBITS), .NBLK(NBLK)) bus_if ();

    pio_master #(
        .PIO_NBITS(NBITS), .NBLK(NBLK), .BLK_SEL_LSB(12),
        .BLK_SEL_NBITS(3), .TIMEOUT_CYC(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .bus(bus_if)
    );

    // Core clock and a half-rate slave pacing strobe.
    always #5 clk = ~clk;
    always @(posedge clk) clk_div <= ~clk_div;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. Completion level on the target line is high for
    // WAIT-cycle indices d .. d+h-1 (d<0: never); preHigh keeps it high from before the request.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int d, input int h, input bit preHigh, input int strayBlk,
                                 input int readyDelay, input logic [31:0] rdSlice,
                                 input logic [31:0] otherFill);
        int          blk;
        bit          in_range;
        bit          done;
        int          resp_cycle;
        int          wait_end;
        logic [3:0]  onehot;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_ctl;
        logic [7:0]  obs_ctl;

        blk      = int'(addr[14:12]);
        in_range = blk < NBLK;
        onehot   = in_range ? 4'(1 << blk) : 4'b0;
        done     = in_range && d >= 0 && d <= TIMEOUT;
        if (!in_range) begin
            resp_cycle = 1; wait_end = 0; exp_err = 1'b1; exp_rdata = 32'hFFFF_FFFF;
        end else if (done) begin
            wait_end = 2 + d; resp_cycle = 3 + d + h; exp_err = 1'b0;
            exp_rdata = wr ? 32'h0 : rdSlice;
        end else begin
            wait_end = 2 + TIMEOUT; resp_cycle = 4 + TIMEOUT; exp_err = 1'b1;
            exp_rdata = 32'hFFFF_FFFF;
        end

        for (int i = 0; i < NBLK; i++) begin
            bus_if.pio_rdata[i*NBITS +: NBITS] = (i == blk) ? rdSlice : otherFill;
        end
        bus_if.pio_ack    = '0;
        bus_if.pio_rvalid = '0;
        if (preHigh && in_range) begin
            if (wr) bus_if.pio_ack[blk] = 1'b1;
            else    bus_if.pio_rvalid[blk] = 1'b1;
        end

        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        checkOutput("accept_ready", 64'(bus_if.req_ready), 64'd1);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;

        for (int c = 1; c <= resp_cycle + readyDelay; c++) begin
            int w;
            bit lvl;
            w   = c - 2;
            lvl = done && (w < d + h) && (w >= d || preHigh);
            bus_if.pio_ack    = '0;
            bus_if.pio_rvalid = '0;
            if (lvl) begin
                if (wr) bus_if.pio_ack[blk] = 1'b1;
                else    bus_if.pio_rvalid[blk] = 1'b1;
            end
            if (strayBlk >= 0 && c >= 2 && c <= wait_end) bus_if.pio_ack[strayBlk] = 1'b1;
            bus_if.resp_ready = (c >= resp_cycle + readyDelay);

            exp_ctl = {(in_range && c <= wait_end) ? onehot : 4'b0,
                       in_range && c == 1 && !wr, in_range && c == 1 && wr,
                       c >= resp_cycle, 1'b0};
            obs_ctl = {bus_if.reg_bs, bus_if.reg_rd, bus_if.reg_wr, bus_if.resp_valid, bus_if.req_ready};
            checkOutput($sformatf("ctl_c%0d", c), 64'(obs_ctl), 64'(exp_ctl));
            if (in_range) checkOutput("bus_addr_din", {bus_if.reg_addr, bus_if.reg_din}, {addr, wdata});
            if (c >= resp_cycle) checkOutput("resp_data_err", 64'({bus_if.resp_err, bus_if.resp_rdata}),
                                             64'({exp_err, exp_rdata}));
            @(posedge clk); #1;
        end
        bus_if.resp_ready = 1'b0;
        bus_if.pio_ack    = '0;
        bus_if.pio_rvalid = '0;
        checkOutput("idle_after_resp", 64'({bus_if.resp_valid, bus_if.req_ready}), 64'b01);
    endtask

    initial begin
        bus_if.req_valid  = 1'b0;
        bus_if.req_wr     = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.resp_ready = 1'b0;
        bus_if.pio_ack    = '0;
        bus_if.pio_rvalid = '0;
        bus_if.pio_rdata  = '0;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 64'({bus_if.reg_bs, bus_if.reg_rd, bus_if.reg_wr, bus_if.resp_valid,
                                      bus_if.req_ready, bus_if.resp_err}), 64'd0);
        checkOutput("reset_data", {bus_if.reg_addr, bus_if.resp_rdata}, 64'd0);
        checkOutput("reset_din", 64'(bus_if.reg_din), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 64'(bus_if.req_ready), 64'd1);

        // Write blk1, ack 4 cycles after strobe held 2 cycles.
        applyStimulus(1'b1, 32'h0000_1004, 32'h0000_0003, 3, 2, 1'b0, -1, 0, 32'h1234_5678, 32'h0);
        // Read blk2 with other slices all-ones.
        applyStimulus(1'b0, 32'h0000_2008, 32'h0, 1, 1, 1'b0, -1, 0, 32'h0000_ABCD, 32'hFFFF_FFFF);
        // Read blk3 with no completion: timeout.
        applyStimulus(1'b0, 32'h0000_3010, 32'h0, -1, 1, 1'b0, -1, 0, 32'h5555_AAAA, 32'h0);
        // Out-of-range block 4.
        applyStimulus(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 0, 1, 1'b0, -1, 0, 32'h0, 32'h0);
        // Write blk0 while a stale ack is still high; it stays high for 6 WAIT/DRAIN cycles.
        applyStimulus(1'b1, 32'h0000_0020, 32'h0000_00A5, 0, 6, 1'b1, -1, 0, 32'h0, 32'h0);
        // Stray ack on blk2 while waiting for blk1.
        applyStimulus(1'b1, 32'h0000_1040, 32'h0BAD_F00D, 5, 1, 1'b0, 2, 0, 32'h0, 32'h0);
        // Host stalls the response for 5 cycles.
        applyStimulus(1'b0, 32'h0000_3044, 32'h0, 2, 2, 1'b0, 1, 5, 32'hCAFE_0042, 32'h1111_1111);

        // Reset pulsed during WAIT, then a normal request.
        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = 1'b1;
        bus_if.req_addr  = 32'h0000_2000;
        bus_if.req_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_pre_wait_bs", 64'(bus_if.reg_bs), 64'b0100);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_ctl", 64'({bus_if.reg_bs, bus_if.reg_rd, bus_if.reg_wr, bus_if.resp_valid,
                                        bus_if.req_ready, bus_if.resp_err}), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 64'(bus_if.req_ready), 64'd1);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 0, 1, 1'b0, -1, 0, 32'h0000_0099, 32'h0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int          blk;
            int          stray;
            blk   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            a     = $urandom;
            a[14:12] = 3'(blk);
            stray = ($urandom_range(0, 1) == 1) ? (blk + 1) % NBLK : -1;
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 6)),
                          int'($urandom_range(1, 3)), 1'b0, stray, int'($urandom_range(0, 3)),
                          $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
